// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte valid/ready handshake into the UART transmitter
interface uart_tx_if;
  logic [7:0] data;
  logic       data_vld;
  logic       data_rdy;

  modport master (output data, output data_vld, input data_rdy);
  modport slave  (input data, input data_vld, output data_rdy);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with one-entry holding register; even parity when UART_TX_PARITY_EN
module uart_tx #(
  parameter int FREQ      = 50_000_000,
  parameter int RATE      = 2_000_000,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);
  localparam int DIV = FREQ / RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          stop_cnt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    hold;
  logic          hold_full, hold_full_nxt;
  logic          tx_d, busy_d;
  logic          tick, load, accept, last_stop;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign accept        = bus.data_vld && bus.data_rdy;
  assign tick          = (cnt == LAST);
  assign last_stop     = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  // load marks every frame start, whether from IDLE or straight out of STOP
  assign load          = (state_nxt == START) && (state != START);
  assign hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);
  assign shift_nxt     = load ? hold :
                         ((state == DATA && tick) ? {1'b0, shift[7:1]} : shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hold_full) state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA: begin
        if (tick && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_nxt = STOP;
`endif
      STOP:  if (tick && last_stop) state_nxt = hold_full ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the transition edge
  always_comb begin
    tx_d = 1'b1;
    case (state_nxt)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_nxt != IDLE) || hold_full_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= 3'd0;
      stop_cnt     <= 1'b0;
      shift        <= 8'h00;
      hold         <= 8'h00;
      hold_full    <= 1'b0;
      bus.data_rdy <= 1'b1;
      tx           <= 1'b1;
      busy         <= 1'b0;
    end else begin
      cnt          <= (state_nxt == IDLE || load || tick) ? '0 : cnt + 1'b1;
      idx          <= (state == DATA && tick) ? idx + 3'd1 :
                      ((state == DATA) ? idx : 3'd0);
      stop_cnt     <= (state_nxt != STOP) ? 1'b0 :
                      ((state == STOP && tick) ? ~stop_cnt : stop_cnt);
      shift        <= shift_nxt;
      if (accept) hold <= bus.data;
      hold_full    <= hold_full_nxt;
      bus.data_rdy <= !hold_full_nxt;
      tx           <= tx_d;
      busy         <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    par <= 1'b0;
    else if (load) par <= ^hold;
  end
`endif

endmodule
